// File: rtl/clk_div_prog_if.sv
// ============================================================================
// Module   : clk_div_prog_if
// Purpose  : Control/status bundle for clk_div_prog (run, divisor load, outputs).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_busy;
  logic             div_err;
  logic             clk_out;
  logic             tick;

  modport master (
    output en, div_val, div_load,
    input  div_busy, div_err, clk_out, tick
  );

  modport slave (
    input  en, div_val, div_load,
    output div_busy, div_err, clk_out, tick
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_prog.sv
// ============================================================================
// Module   : clk_div_prog
// Purpose  : Runtime-programmable clock divider; divisor reloads apply only at
//            period boundaries. Optional macro CLK_DIV_ODD_50_EN adds a negedge
//            flop for an exact 50% duty cycle on odd divisors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  clk_div_prog_if.slave     bus
);

  localparam logic [WIDTH-1:0] c_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] c_ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_TWO         = WIDTH'(2);

  generate
    if ((DEFAULT_DIV < 2) ||
        (longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_default_div
      $error("clk_div_prog: DEFAULT_DIV must be in 2 .. 2^WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] r_pend;
  logic             r_busy;
  logic             r_err;
  logic             r_out;
  logic             r_tick;

  logic [WIDTH-1:0] w_low;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_apply;

  // Low phase gets the extra cycle on odd divisors: L = D - floor(D/2).
  assign w_low      = r_div_act - (r_div_act >> 1);
  assign w_wrap     = (r_cnt == (r_div_act - c_ONE));
  assign w_cnt_nxt  = w_wrap ? '0 : (r_cnt + c_ONE);
  assign w_load_ok  = bus.div_load && (bus.div_val >= c_TWO);
  assign w_load_bad = bus.div_load && (bus.div_val <  c_TWO);
  // Idle behaves like a period boundary for the pending divisor.
  assign w_apply    = !bus.en || w_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_div_act <= c_DEFAULT_DIV;
      r_pend    <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_out     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_err <= w_load_bad;

      if (w_apply && r_busy) begin
        r_div_act <= r_pend;
      end

      // A load coinciding with an apply point becomes the next pending value.
      if (w_load_ok) begin
        r_pend <= bus.div_val;
        r_busy <= 1'b1;
      end else if (w_apply) begin
        r_busy <= 1'b0;
      end

      if (bus.en) begin
        r_cnt  <= w_cnt_nxt;
        r_out  <= (w_cnt_nxt >= w_low);
        r_tick <= w_wrap;
      end else begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_ODD_50_EN
  logic r_odd;
  logic r_neg;

  // Parity of the divisor that produced the current r_out value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_odd <= 1'b0;
    end else if (bus.en) begin
      r_odd <= r_div_act[0];
    end else begin
      r_odd <= 1'b0;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_neg <= 1'b0;
    end else if (!bus.en) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_out;
    end
  end

  assign bus.clk_out = r_out | (r_neg & r_odd);
`else
  assign bus.clk_out = r_out;
`endif

  assign bus.tick     = r_tick;
  assign bus.div_busy = r_busy;
  assign bus.div_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// ============================================================================
// Module   : tb_clk_div_prog
// Purpose  : Directed self-checking bench for clk_div_prog (default build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_prog;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  clk_div_prog_if #(.WIDTH(8)) bus ();

  clk_div_prog #(
    .WIDTH       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [255:0] outs;
  logic [255:0] ticks;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records clk_out/tick after each of n edges; first edge lands in the MSB.
  task automatic run(input int n);
    outs  = '0;
    ticks = '0;
    repeat (n) begin
      step();
      outs  = {outs[254:0],  bus.clk_out};
      ticks = {ticks[254:0], bus.tick};
    end
  endtask

  task automatic load(input logic [7:0] v);
    bus.div_val  = v;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.tick && k < budget);
    n_total++;
    if (bus.tick !== 1'b1) $display("FAIL wait_tick: no tick within %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.div_val = '0; bus.div_load = 1'b0;
    #12;
    n_total++; if (bus.clk_out !== 1'b0)  $display("FAIL reset_clk_out: got %b want 0", bus.clk_out);  else n_pass++;
    n_total++; if (bus.tick !== 1'b0)     $display("FAIL reset_tick: got %b want 0", bus.tick);        else n_pass++;
    n_total++; if (bus.div_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.div_busy);    else n_pass++;
    n_total++; if (bus.div_err !== 1'b0)  $display("FAIL reset_err: got %b want 0", bus.div_err);      else n_pass++;
  endtask

  task automatic test_default();
    step();
    reset  = 1'b1;
    bus.en = 1'b1;
    run(8);
    n_total++; if (outs[7:0] !== 8'b01100110)  $display("FAIL default_clk_out: got %b want 01100110", outs[7:0]);  else n_pass++;
    n_total++; if (ticks[7:0] !== 8'b00010001) $display("FAIL default_tick: got %b want 00010001", ticks[7:0]); else n_pass++;
  endtask

  task automatic test_reload();
    load(8'd5);
    n_total++; if (bus.div_busy !== 1'b1) $display("FAIL reload_busy_set: got %b want 1", bus.div_busy); else n_pass++;
    step(); step();
    n_total++; if (bus.div_busy !== 1'b1) $display("FAIL reload_busy_hold: got %b want 1", bus.div_busy); else n_pass++;
    step();
    n_total++; if ({bus.div_busy, bus.tick} !== 2'b01) $display("FAIL reload_wrap: busy,tick got %b want 01", {bus.div_busy, bus.tick}); else n_pass++;
    run(5);
    n_total++; if (outs[4:0] !== 5'b00110)  $display("FAIL reload_d5_clk_out: got %b want 00110", outs[4:0]);  else n_pass++;
    n_total++; if (ticks[4:0] !== 5'b00001) $display("FAIL reload_d5_tick: got %b want 00001", ticks[4:0]); else n_pass++;
  endtask

  task automatic test_last_wins();
    load(8'd7);
    load(8'd9);
    run(3);
    n_total++; if (ticks[2:0] !== 3'b001) $display("FAIL lastwins_d5_wrap: got %b want 001", ticks[2:0]); else n_pass++;
    load(8'd4);
    n_total++; if (bus.clk_out !== 1'b0) $display("FAIL lastwins_d9_first: got %b want 0", bus.clk_out); else n_pass++;
    run(7);
    n_total++; if ({outs[6:0], ticks[6:0]} !== {7'b0001111, 7'b0000000})
      $display("FAIL lastwins_d9_body: out,tick got %b %b want 0001111 0000000", outs[6:0], ticks[6:0]); else n_pass++;
    // Load lands exactly on the wrap cycle of the D=9 period.
    load(8'd3);
    n_total++; if ({bus.tick, bus.clk_out, bus.div_busy} !== 3'b101)
      $display("FAIL wrapload_edge: tick,out,busy got %b want 101", {bus.tick, bus.clk_out, bus.div_busy}); else n_pass++;
    run(4);
    n_total++; if ({outs[3:0], ticks[3:0]} !== 8'b0110_0001)
      $display("FAIL wrapload_d4: out,tick got %b %b want 0110 0001", outs[3:0], ticks[3:0]); else n_pass++;
    n_total++; if (bus.div_busy !== 1'b0) $display("FAIL wrapload_busy_clear: got %b want 0", bus.div_busy); else n_pass++;
    run(3);
    n_total++; if ({outs[2:0], ticks[2:0]} !== 6'b010_001)
      $display("FAIL wrapload_d3: out,tick got %b %b want 010 001", outs[2:0], ticks[2:0]); else n_pass++;
  endtask

  task automatic test_err();
    load(8'd0);
    n_total++; if ({bus.div_err, bus.div_busy} !== 2'b10) $display("FAIL err_zero: err,busy got %b want 10", {bus.div_err, bus.div_busy}); else n_pass++;
    step();
    n_total++; if (bus.div_err !== 1'b0) $display("FAIL err_zero_clear: got %b want 0", bus.div_err); else n_pass++;
    load(8'd1);
    n_total++; if ({bus.div_err, bus.div_busy} !== 2'b10) $display("FAIL err_one: err,busy got %b want 10", {bus.div_err, bus.div_busy}); else n_pass++;
    step();
    n_total++; if (bus.div_err !== 1'b0) $display("FAIL err_one_clear: got %b want 0", bus.div_err); else n_pass++;
    wait_tick(20);
    run(3);
    n_total++; if ({outs[2:0], ticks[2:0]} !== 6'b010_001)
      $display("FAIL err_d3_kept: out,tick got %b %b want 010 001", outs[2:0], ticks[2:0]); else n_pass++;
  endtask

  task automatic test_idle();
    load(8'd6);
    n_total++; if (bus.div_busy !== 1'b1) $display("FAIL idle_busy_set: got %b want 1", bus.div_busy); else n_pass++;
    load(8'd0);
    n_total++; if ({bus.div_err, bus.div_busy} !== 2'b11) $display("FAIL idle_err_keeps_pend: err,busy got %b want 11", {bus.div_err, bus.div_busy}); else n_pass++;
    bus.en = 1'b0;
    step();
    n_total++; if ({bus.clk_out, bus.tick, bus.div_busy} !== 3'b000)
      $display("FAIL idle_enter: out,tick,busy got %b want 000", {bus.clk_out, bus.tick, bus.div_busy}); else n_pass++;
    step();
    n_total++; if (bus.clk_out !== 1'b0) $display("FAIL idle_hold: got %b want 0", bus.clk_out); else n_pass++;
    bus.en = 1'b1;
    run(6);
    n_total++; if ({outs[5:0], ticks[5:0]} !== 12'b001110_000001)
      $display("FAIL idle_restart_d6: out,tick got %b %b want 001110 000001", outs[5:0], ticks[5:0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    load(8'd255);
    wait_tick(20);
    run(200);
    n_total++; if (bus.clk_out !== 1'b1) $display("FAIL d255_high_phase: got %b want 1", bus.clk_out); else n_pass++;
    load(8'd10);
    #3 reset = 1'b0;
    #1;
    n_total++; if ({bus.clk_out, bus.tick, bus.div_busy} !== 3'b000)
      $display("FAIL async_reset: out,tick,busy got %b want 000", {bus.clk_out, bus.tick, bus.div_busy}); else n_pass++;
    step();
    reset = 1'b1;
    run(4);
    n_total++; if ({outs[3:0], ticks[3:0]} !== 8'b0110_0001)
      $display("FAIL post_reset_default: out,tick got %b %b want 0110 0001", outs[3:0], ticks[3:0]); else n_pass++;
    load(8'd255);
    wait_tick(20);
    for (int p = 0; p < 2; p++) begin
      run(255);
      n_total++; if (outs[254:0] !== 255'((256'd1 << 128) - 256'd2))
        $display("FAIL d255_shape: period %0d highs=%0d want 127 in cnt 128..254", p, $countones(outs[254:0])); else n_pass++;
      n_total++; if (ticks[254:0] !== 255'd1)
        $display("FAIL d255_tick: period %0d tick count=%0d want single at end", p, $countones(ticks[254:0])); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_reload();
    test_last_wins();
    test_err();
    test_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
